// File: rtl/clk_gen_pkg.sv
// Shared types and constants for the clock-source generation blocks.
package clk_gen_pkg;

  localparam int unsigned GUARD_CNT_W = 8;

  typedef enum logic {
    StRoute,
    StGuard
  } tick_demux_state_e;

endpackage

// File: rtl/tick_demux_1_to_2.sv
// Routes one tick stream to one of two registered outputs, with a break-before-make
// guard interval on every change of destination.
module tick_demux_1_to_2
  import clk_gen_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick_in,
  input  logic en,
  input  logic sel,
  output logic tick_out0,
  output logic tick_out1,
  output logic active_sel,
  output logic switching,
  output logic switch_done
);

  if (GUARD_CYCLES < 1 || GUARD_CYCLES > 255) begin : g_bad_guard_cycles
    $error("tick_demux_1_to_2: GUARD_CYCLES must be in 1..255");
  end

  localparam logic [GUARD_CNT_W-1:0] CntInit = GUARD_CNT_W'(GUARD_CYCLES - 1);

  tick_demux_state_e      state_q, state_d;
  logic [GUARD_CNT_W-1:0] cnt_q, cnt_d;
  logic                   target_q, target_d;
  logic                   active_q, active_d;
  logic                   out0_q, out0_d;
  logic                   out1_q, out1_d;
  logic                   done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;
    active_d = active_q;
    out0_d   = 1'b0;
    out1_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      StRoute: begin
        if (sel != active_q) begin
          // The tick sampled on the switching edge is dropped.
          state_d  = StGuard;
          target_d = sel;
          cnt_d    = CntInit;
        end else begin
          out0_d = en & tick_in & ~active_q;
          out1_d = en & tick_in & active_q;
        end
      end
      StGuard: begin
        if (cnt_q == '0) begin
          state_d  = StRoute;
          active_d = target_q;
          done_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StRoute;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StRoute;
      cnt_q    <= '0;
      target_q <= 1'b0;
      active_q <= 1'b0;
      out0_q   <= 1'b0;
      out1_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      active_q <= active_d;
      out0_q   <= out0_d;
      out1_q   <= out1_d;
      done_q   <= done_d;
    end
  end

  assign tick_out0   = out0_q;
  assign tick_out1   = out1_q;
  assign active_sel  = active_q;
  assign switch_done = done_q;
  assign switching   = (state_q == StGuard);

endmodule

// File: tb/tb_tick_demux_1_to_2.sv
// Directed checks on a GUARD_CYCLES=2 instance plus a random scoreboard run on
// GUARD_CYCLES=1 and GUARD_CYCLES=5 instances sharing the same stimulus.
module tb_tick_demux_1_to_2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic tick_in = 1'b0;
  logic en = 1'b0;
  logic sel = 1'b0;

  logic o0_2, o1_2, act_2, sw_2, done_2;
  logic o0_1, o1_1, act_1, sw_1, done_1;
  logic o0_5, o1_5, act_5, sw_5, done_5;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_demux_1_to_2 #(.GUARD_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .en(en), .sel(sel),
    .tick_out0(o0_2), .tick_out1(o1_2), .active_sel(act_2),
    .switching(sw_2), .switch_done(done_2)
  );

  tick_demux_1_to_2 #(.GUARD_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .en(en), .sel(sel),
    .tick_out0(o0_1), .tick_out1(o1_1), .active_sel(act_1),
    .switching(sw_1), .switch_done(done_1)
  );

  tick_demux_1_to_2 #(.GUARD_CYCLES(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .en(en), .sel(sel),
    .tick_out0(o0_5), .tick_out1(o1_5), .active_sel(act_5),
    .switching(sw_5), .switch_done(done_5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Observed {tick_out0, tick_out1, active_sel, switching, switch_done} of the G=2 instance.
  function automatic logic [4:0] obs2();
    return {o0_2, o1_2, act_2, sw_2, done_2};
  endfunction

  task automatic check2(input string name, input logic [4:0] exp);
    checks++;
    if (obs2() !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {o0,o1,act,sw,done}=%b expected %b", name, $time, obs2(), exp);
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    sel = 1'b0; en = 1'b1; tick_in = 1'b1;
    #1;
    check2("reset_async", 5'b00000);
    tick();
    check2("reset_held", 5'b00000);
    #2 rst_n = 1'b1;
  endtask

  task automatic test_routing();
    sel = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick_in = (i % 3 == 0);
      tick();
      check2($sformatf("route0_%0d", i), {tick_in, 4'b0000});
    end
  endtask

  task automatic test_switch();
    tick_in = 1'b1; en = 1'b1; sel = 1'b1;
    tick();
    check2("switch_k", 5'b00010);
    tick();
    check2("switch_k1", 5'b00010);
    tick();
    check2("switch_k2_done", 5'b00101);
    tick();
    check2("switch_k3_first_tick", 5'b01100);
    tick();
    check2("switch_k4", 5'b01100);
  endtask

  task automatic test_glitch();
    do_reset();
    sel = 1'b0; en = 1'b1; tick_in = 1'b1;
    tick();
    check2("glitch_pre", 5'b10000);
    sel = 1'b1;
    tick();
    check2("glitch_a", 5'b00010);
    sel = 1'b0;
    tick();
    check2("glitch_a1_ignored", 5'b00010);
    tick();
    check2("glitch_a2_done1", 5'b00101);
    tick();
    check2("glitch_a3_second_guard", 5'b00110);
    tick();
    check2("glitch_a4", 5'b00110);
    tick();
    check2("glitch_a5_done0", 5'b00001);
    tick();
    check2("glitch_a6_route0", 5'b10000);
  endtask

  task automatic test_enable_gating();
    en = 1'b0; tick_in = 1'b1; sel = 1'b1;
    tick();
    check2("engate_k", 5'b00010);
    tick();
    check2("engate_k1", 5'b00010);
    tick();
    check2("engate_k2_done", 5'b00101);
    tick();
    check2("engate_k3_gated", 5'b00100);
    en = 1'b1;
    tick();
    check2("engate_k4_open", 5'b01100);
  endtask

  task automatic test_reset_mid_guard();
    sel = 1'b0; en = 1'b1; tick_in = 1'b1;
    tick();
    check2("midrst_guard", 5'b00110);
    #3 rst_n = 1'b0;
    #1;
    check2("midrst_async", 5'b00000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check2($sformatf("midrst_after_%0d", i), 5'b10000);
    end
  endtask

  task automatic test_random_stress();
    int          gc[2];
    int          rem[2];
    logic        m_act[2], m_tgt[2], m_o0[2], m_o1[2], m_done[2];
    int          m_cnt0[2], m_cnt1[2], d_cnt0[2], d_cnt1[2];
    logic [4:0]  exp_v, got_v;
    gc[0] = 1;
    gc[1] = 5;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0; m_act[i] = 1'b0; m_tgt[i] = 1'b0;
      m_cnt0[i] = 0; m_cnt1[i] = 0; d_cnt0[i] = 0; d_cnt1[i] = 0;
    end
    for (int c = 0; c < 10000; c++) begin
      tick_in = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 7) == 0) sel = ~sel;
      // Reference: rem counts guard edges still to go before the new route takes effect.
      for (int i = 0; i < 2; i++) begin
        m_o0[i] = 1'b0; m_o1[i] = 1'b0; m_done[i] = 1'b0;
        if (rem[i] > 0) begin
          rem[i]--;
          if (rem[i] == 0) begin
            m_act[i] = m_tgt[i];
            m_done[i] = 1'b1;
          end
        end else if (sel != m_act[i]) begin
          rem[i] = gc[i];
          m_tgt[i] = sel;
        end else begin
          m_o0[i] = en && tick_in && !m_act[i];
          m_o1[i] = en && tick_in && m_act[i];
        end
      end
      tick();
      for (int i = 0; i < 2; i++) begin
        exp_v = {m_o0[i], m_o1[i], m_act[i], (rem[i] > 0), m_done[i]};
        got_v = (i == 0) ? {o0_1, o1_1, act_1, sw_1, done_1} : {o0_5, o1_5, act_5, sw_5, done_5};
        m_cnt0[i] += int'(m_o0[i]);
        m_cnt1[i] += int'(m_o1[i]);
        d_cnt0[i] += int'(got_v[4]);
        d_cnt1[i] += int'(got_v[3]);
        checks++;
        if (got_v[4] & got_v[3]) begin
          errors++;
          $display("FAIL stress_overlap G=%0d cycle %0d: both outputs high", gc[i], c);
        end
        checks++;
        if (got_v !== exp_v) begin
          errors++;
          $display("FAIL stress_cycle G=%0d cycle %0d: got %b expected %b", gc[i], c, got_v, exp_v);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (d_cnt0[i] != m_cnt0[i]) begin
        errors++;
        $display("FAIL stress_count0 G=%0d: got %0d expected %0d", gc[i], d_cnt0[i], m_cnt0[i]);
      end
      checks++;
      if (d_cnt1[i] != m_cnt1[i]) begin
        errors++;
        $display("FAIL stress_count1 G=%0d: got %0d expected %0d", gc[i], d_cnt1[i], m_cnt1[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_routing();
    test_switch();
    test_glitch();
    test_enable_gating();
    test_reset_mid_guard();
    test_random_stress();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
